i2c_reg_ctrl: RTL and testbench
===============================

// Module: i2c_reg_ctrl
// PURPOSE
//  Sequences the I2C target byte engine into register-bank accesses: 1st written byte = register
//  pointer, following written bytes = data writes, read bytes = data reads, pointer auto-incrementing.
//  Arbitrates one single-port register bank between the I2C side and a local fabric requester.
//  Sits between the I2C target (SDA/SCL, in main) and the user register bank.
// PARAMETERS
//  ADDR_W   4   register pointer width; bank depth = 2**ADDR_W
//  DATA_W   8   register width; must be 8 (I2C byte)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       async active-low reset
//  i2c_start    in   1       pulse: START/rep-START with own address matched
//  i2c_rw       in   1       direction of current transfer, valid with i2c_start (1=read)
//  i2c_stop     in   1       pulse: STOP seen
//  i2c_rx_valid in   1       pulse: written byte received (after ACK)
//  i2c_rx_data  in   8       received byte, valid with i2c_rx_valid
//  i2c_tx_req   in   1       pulse: engine needs next byte to transmit
//  i2c_tx_data  out  8       byte to transmit
//  i2c_tx_valid out  1       pulse: i2c_tx_data valid
//  loc_req      in   1       local access request; held until loc_gnt
//  loc_we       in   1       local write(1)/read(0)
//  loc_addr     in   ADDR_W  local address
//  loc_wdata    in   8       local write data
//  loc_gnt      out  1       local request accepted this cycle
//  loc_rvalid   out  1       pulse: loc_rdata valid (cycle after read grant)
//  loc_rdata    out  8       local read data
//  reg_addr     out  ADDR_W  bank address
//  reg_we       out  1       bank write strobe
//  reg_re       out  1       bank read strobe; reg_rdata valid next cycle
//  reg_wdata    out  8       bank write data
//  reg_rdata    in   8       bank read data
//  busy         out  1       1 while FSM not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, all outputs 0; reset mid-transfer aborts, no bank access emitted.
//  FSM: IDLE, PTR, WRITE, READ.
//   any state + i2c_start: rw=0 -> PTR, rw=1 -> READ (ptr kept: combined write-ptr/rep-START/read).
//   PTR + rx_valid: ptr <= rx_data[ADDR_W-1:0] (upper bits ignored) -> WRITE.
//   WRITE + rx_valid: bank write at ptr, ptr <= ptr+1.
//   READ + tx_req: bank read at ptr, ptr <= ptr+1.
//   i2c_stop (any state, no start same cycle) -> IDLE; ptr retained across transfers.
//   rx_valid in READ or IDLE, tx_req in PTR/WRITE/IDLE: ignored, no bank access.
//  Same-cycle events: rx_valid+stop -> byte processed, then IDLE; start wins over stop.
//  ptr wraps 2**ADDR_W-1 -> 0, no error.
//  Arbitration, fixed priority I2C > local, decided combinationally per cycle:
//   I2C op present -> it drives reg_*; loc_gnt=0; local keeps loc_req high, retries next cycle.
//   Else loc_req -> loc_gnt=1, reg_addr=loc_addr, reg_we=loc_we, reg_re=!loc_we.
//   I2C ops are >=1 per byte-time apart, so local starvation bounded to 1 cycle.
//  Latency: I2C read: tx_req at cycle N -> i2c_tx_valid+data at N+1 (bank read registered).
//   I2C write: reg_we asserted in rx_valid cycle. Local read: loc_rvalid at gnt+1.
//  Readback source tracked by 1-bit registered tag; tx_data/loc_rdata hold last value.
// STRUCTURE
//  Package i2c_reg_pkg: state enum (IDLE/PTR/WRITE/READ), ADDR_W default, DATA_W=8 constant.
//  Single module; arbiter is a small comb block, no sub-module.
// TESTING
//  1 write: start(rw=0), rx 0x03, rx 0xA5, rx 0x5A, stop -> reg[3]=A5, reg[4]=5A, ptr=5, busy->0.
//  2 read: start(rw=1), 2x tx_req -> tx_data A5? no: ptr=5 -> reg[5], reg[6]; each valid 1 cyc later.
//  3 combined: start rw=0, rx 0x0F, rep-start rw=1, tx_req x2 -> reg[15], reg[0] (wrap).
//  4 collision: loc_req(write 0x02=0x77) same cycle as I2C rx data -> I2C write first, loc_gnt 1 cyc later.
//  5 ptr byte 0xF3 with ADDR_W=4 -> ptr=3; rx_valid+stop same cycle -> write done, IDLE.
//  6 rst_n low between ptr byte and data byte -> no reg_we, outputs 0, ptr=0.

Source files
------------

// File: rtl/i2c_reg_pkg.sv
// Shared types and constants for the I2C register-bank sequencer.
// The byte width is fixed by the I2C transport; the pointer width is a default.
package i2c_reg_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PTR   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

endpackage

// File: rtl/i2c_reg_ctrl.sv
// Turns I2C target byte events into register-bank accesses with an auto-incrementing
// pointer, and shares the single bank port with a local requester (I2C has priority).
module i2c_reg_ctrl
  import i2c_reg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_start,
  input  logic              i2c_rw,
  input  logic              i2c_stop,
  input  logic              i2c_rx_valid,
  input  logic [DATA_W-1:0] i2c_rx_data,
  input  logic              i2c_tx_req,
  output logic [DATA_W-1:0] i2c_tx_data,
  output logic              i2c_tx_valid,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_gnt,
  output logic              loc_rvalid,
  output logic [DATA_W-1:0] loc_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_we,
  output logic              reg_re,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_ld;
  logic              wr_op;
  logic              rd_op;
  logic              i2c_op;
  logic              loc_rd;

  logic              rd_pend_p1;
  logic              rd_tag_p1;
  logic [DATA_W-1:0] tx_hold_p1;
  logic [DATA_W-1:0] loc_hold_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A new START always wins; a STOP alongside a byte still lets the byte complete.
  always_comb begin
    state_nxt = state;
    if (i2c_start) begin
      state_nxt = i2c_rw ? READ : PTR;
    end else if (i2c_stop) begin
      state_nxt = IDLE;
    end else if (state == PTR && i2c_rx_valid) begin
      state_nxt = WRITE;
    end
  end

  always_comb begin
    ptr_ld    = (state == PTR) && i2c_rx_valid;
    wr_op     = (state == WRITE) && i2c_rx_valid;
    rd_op     = (state == READ) && i2c_tx_req;
    i2c_op    = wr_op || rd_op;
    loc_gnt   = loc_req && !i2c_op;
    loc_rd    = loc_gnt && !loc_we;
    reg_addr  = '0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    reg_wdata = '0;
    if (i2c_op) begin
      reg_addr  = ptr;
      reg_we    = wr_op;
      reg_re    = rd_op;
      reg_wdata = wr_op ? i2c_rx_data : '0;
    end else if (loc_gnt) begin
      reg_addr  = loc_addr;
      reg_we    = loc_we;
      reg_re    = !loc_we;
      reg_wdata = loc_we ? loc_wdata : '0;
    end
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (ptr_ld) begin
      ptr <= i2c_rx_data[ADDR_W-1:0];
    end else if (i2c_op) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

  // Stage p1: bank read data returns; tag says which requester owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_p1  <= 1'b0;
      rd_tag_p1   <= 1'b0;
      tx_hold_p1  <= '0;
      loc_hold_p1 <= '0;
    end else begin
      rd_pend_p1 <= rd_op || loc_rd;
      rd_tag_p1  <= loc_rd;
      if (rd_pend_p1 && !rd_tag_p1) begin
        tx_hold_p1 <= reg_rdata;
      end
      if (rd_pend_p1 && rd_tag_p1) begin
        loc_hold_p1 <= reg_rdata;
      end
    end
  end

  always_comb begin
    i2c_tx_valid = rd_pend_p1 && !rd_tag_p1;
    loc_rvalid   = rd_pend_p1 && rd_tag_p1;
    i2c_tx_data  = i2c_tx_valid ? reg_rdata : tx_hold_p1;
    loc_rdata    = loc_rvalid ? reg_rdata : loc_hold_p1;
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: directed transfers plus randomized I2C/local traffic,
// checked every cycle against a transaction-level model of pointer, bank and readback.
module tb_i2c_reg_ctrl;

  logic       clk;
  logic       rst_n = 1'b0;
  logic       i2c_start = 1'b0;
  logic       i2c_rw = 1'b0;
  logic       i2c_stop = 1'b0;
  logic       i2c_rx_valid = 1'b0;
  logic [7:0] i2c_rx_data = 8'h00;
  logic       i2c_tx_req = 1'b0;
  logic [7:0] i2c_tx_data;
  logic       i2c_tx_valid;
  logic       loc_req = 1'b0;
  logic       loc_we = 1'b0;
  logic [3:0] loc_addr = 4'h0;
  logic [7:0] loc_wdata = 8'h00;
  logic       loc_gnt;
  logic       loc_rvalid;
  logic [7:0] loc_rdata;
  logic [3:0] reg_addr;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;

  int ntests = 0;
  int nfail = 0;

  i2c_reg_ctrl #(.ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_stop(i2c_stop),
    .i2c_rx_valid(i2c_rx_valid), .i2c_rx_data(i2c_rx_data),
    .i2c_tx_req(i2c_tx_req), .i2c_tx_data(i2c_tx_data), .i2c_tx_valid(i2c_tx_valid),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_gnt(loc_gnt), .loc_rvalid(loc_rvalid), .loc_rdata(loc_rdata),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_re(reg_re),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The register bank the controller drives: one-cycle read latency.
  logic [7:0] bank [16];
  bit         bank_init = 1'b0;
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 16; i++) bank[i] <= 8'h10 + 8'(i);
      bank_init <= 1'b1;
    end else begin
      if (reg_we) bank[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= bank[reg_addr];
    end
  end

  // Reference model. mode: 0 idle, 1 awaiting pointer, 2 writing, 3 reading.
  int         m_mode = 0;
  logic [3:0] m_ptr = 4'h0;
  logic [7:0] m_mem [16];
  bit         m_init = 1'b0;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_lrd = 8'h00;
  logic       m_txv = 1'b0;
  logic       m_lrv = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!m_init) begin
        for (int i = 0; i < 16; i++) m_mem[i] <= 8'h10 + 8'(i);
        m_init <= 1'b1;
      end
      m_mode <= 0;
      m_ptr  <= 4'h0;
      m_tx   <= 8'h00;
      m_lrd  <= 8'h00;
      m_txv  <= 1'b0;
      m_lrv  <= 1'b0;
    end else begin
      m_txv <= 1'b0;
      m_lrv <= 1'b0;
      if (i2c_rx_valid && m_mode == 1) begin
        m_ptr  <= i2c_rx_data[3:0];
        m_mode <= 2;
      end else if (i2c_rx_valid && m_mode == 2) begin
        m_mem[m_ptr] <= i2c_rx_data;
        m_ptr <= m_ptr + 4'd1;
      end else if (i2c_tx_req && m_mode == 3) begin
        m_tx  <= m_mem[m_ptr];
        m_txv <= 1'b1;
        m_ptr <= m_ptr + 4'd1;
      end
      if (loc_req && !((i2c_rx_valid && m_mode == 2) || (i2c_tx_req && m_mode == 3))) begin
        if (loc_we) begin
          m_mem[loc_addr] <= loc_wdata;
        end else begin
          m_lrd <= m_mem[loc_addr];
          m_lrv <= 1'b1;
        end
      end
      if (i2c_start) m_mode <= i2c_rw ? 3 : 1;
      else if (i2c_stop) m_mode <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic e_wr, e_rd, e_io, e_gnt, e_we, e_re;
    logic [3:0] e_addr;
    logic [7:0] e_wd;
    e_wr   = i2c_rx_valid && m_mode == 2;
    e_rd   = i2c_tx_req && m_mode == 3;
    e_io   = e_wr || e_rd;
    e_gnt  = loc_req && !e_io;
    e_we   = e_wr || (e_gnt && loc_we);
    e_re   = e_rd || (e_gnt && !loc_we);
    e_addr = e_io ? m_ptr : loc_addr;
    e_wd   = e_wr ? i2c_rx_data : loc_wdata;
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("reg_we", 32'(reg_we), 32'(e_we));
    chk("reg_re", 32'(reg_re), 32'(e_re));
    chk("loc_gnt", 32'(loc_gnt), 32'(e_gnt));
    if (e_we || e_re) chk("reg_addr", 32'(reg_addr), 32'(e_addr));
    if (e_we) chk("reg_wdata", 32'(reg_wdata), 32'(e_wd));
    chk("tx_valid", 32'(i2c_tx_valid), 32'(m_txv));
    chk("tx_data", 32'(i2c_tx_data), 32'(m_tx));
    chk("loc_rvalid", 32'(loc_rvalid), 32'(m_lrv));
    chk("loc_rdata", 32'(loc_rdata), 32'(m_lrd));
  endtask

  task automatic step(input bit st, input bit rw, input bit sp, input bit rxv,
                      input logic [7:0] rxd, input bit txr);
    i2c_start    = st;
    i2c_rw       = rw;
    i2c_stop     = sp;
    i2c_rx_valid = rxv;
    i2c_rx_data  = rxd;
    i2c_tx_req   = txr;
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    i2c_start    = 1'b0;
    i2c_stop     = 1'b0;
    i2c_rx_valid = 1'b0;
    i2c_tx_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 0);
  endtask

  // Local requester: holds loc_req until granted; takes directed or random requests.
  int         dir_seq = 0;
  int         dir_done = 0;
  bit         dir_we = 1'b0;
  logic [3:0] dir_addr = 4'h0;
  logic [7:0] dir_wdata = 8'h00;
  bit         loc_rand = 1'b0;

  initial begin
    bit g;
    forever begin
      @(negedge clk);
      g = loc_gnt;
      @(posedge clk);
      #2;
      if (g) loc_req = 1'b0;
      if (!loc_req) begin
        if (dir_seq != dir_done) begin
          loc_req   = 1'b1;
          loc_we    = dir_we;
          loc_addr  = dir_addr;
          loc_wdata = dir_wdata;
          dir_done  = dir_seq;
        end else if (loc_rand && $urandom_range(0, 3) == 0) begin
          loc_req   = 1'b1;
          loc_we    = 1'($urandom_range(0, 1));
          loc_addr  = 4'($urandom_range(0, 15));
          loc_wdata = 8'($urandom_range(0, 255));
        end
      end
    end
  end

  initial begin
    int r;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_data", 32'(i2c_tx_data), 0);
    chk("rst_reg_we", 32'(reg_we), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // 1: write pointer 3, data A5, 5A
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 1, 8'h03, 0);
    step(0, 0, 0, 1, 8'hA5, 0);
    step(0, 0, 0, 1, 8'h5A, 0);
    step(0, 0, 1, 0, 8'h00, 0);
    idle(1);
    chk("t1_bank3", 32'(bank[3]), 32'h A5);
    chk("t1_bank4", 32'(bank[4]), 32'h 5A);
    chk("t1_busy", 32'(busy), 0);

    // 2: read from retained pointer 5
    step(1, 1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("t2_valid0", 32'(i2c_tx_valid), 1);
    chk("t2_data0", 32'(i2c_tx_data), 32'h15);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("t2_data1", 32'(i2c_tx_data), 32'h16);
    step(0, 0, 1, 0, 8'h00, 0);
    chk("t2_hold", 32'(i2c_tx_data), 32'h16);

    // 3: combined write-pointer / repeated START / read with wrap
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 1, 8'h0F, 0);
    step(1, 1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("t3_data15", 32'(i2c_tx_data), 32'h1F);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("t3_wrap0", 32'(i2c_tx_data), 32'h10);
    step(0, 0, 1, 0, 8'h00, 0);

    // 4: local write collides with an I2C data byte
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 1, 8'h08, 0);
    dir_we = 1'b1; dir_addr = 4'h2; dir_wdata = 8'h77; dir_seq++;
    i2c_rx_valid = 1'b1;
    i2c_rx_data  = 8'h44;
    @(negedge clk);
    compare_cycle();
    chk("t4_gnt_blocked", 32'(loc_gnt), 0);
    chk("t4_i2c_addr", 32'(reg_addr), 32'h8);
    @(posedge clk);
    #1;
    i2c_rx_valid = 1'b0;
    @(negedge clk);
    compare_cycle();
    chk("t4_gnt_late", 32'(loc_gnt), 1);
    chk("t4_loc_addr", 32'(reg_addr), 32'h2);
    @(posedge clk);
    #1;
    step(0, 0, 1, 0, 8'h00, 0);
    idle(1);
    chk("t4_bank8", 32'(bank[8]), 32'h44);
    chk("t4_bank2", 32'(bank[2]), 32'h77);
    dir_we = 1'b0; dir_addr = 4'h2; dir_seq++;
    idle(1);
    chk("t4_lrvalid", 32'(loc_rvalid), 1);
    chk("t4_lrdata", 32'(loc_rdata), 32'h77);

    // 5: pointer upper bits ignored; data byte together with STOP
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 1, 8'hF3, 0);
    step(0, 0, 1, 1, 8'h99, 0);
    idle(1);
    chk("t5_bank3", 32'(bank[3]), 32'h99);
    chk("t5_busy", 32'(busy), 0);

    // 6: reset between pointer and data byte
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 1, 8'h06, 0);
    rst_n = 1'b0;
    step(0, 0, 0, 1, 8'hEE, 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_we", 32'(reg_we), 0);
    chk("t6_tx_data", 32'(i2c_tx_data), 0);
    chk("t6_bank6", 32'(bank[6]), 32'h16);
    rst_n = 1'b1;
    idle(1);
    step(1, 1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("t6_ptr0", 32'(i2c_tx_data), 32'h10);
    step(0, 0, 1, 0, 8'h00, 0);

    // Random traffic on both sides
    loc_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      step(r < 4, 1'($urandom_range(0, 1)), (r >= 4 && r < 8) || r >= 97,
           (r >= 8 && r < 40) || r >= 97, 8'($urandom_range(0, 255)),
           r >= 40 && r < 70);
    end
    loc_rand = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
